// File: rtl/exe_stage_hs.sv
`default_nettype none
// ============================================================================
// Module   : exe_stage_hs
// Brief    : Handshaked MIPS execute stage. Holds one instruction, evaluates
//            the ALU with signed-overflow trap, and runs an iterative
//            restoring divider (DIV/DIVU) that stalls the stage until done.
// Revision : 1.0 - initial release
// ============================================================================
module exe_stage_hs #(
  parameter int XLEN  = 32,
  parameter int EXC_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               id_to_exe_valid,
  output logic               exe_allowin,
  input  logic [XLEN-1:0]    id_pc,
  input  logic [XLEN-1:0]    id_src_a,
  input  logic [XLEN-1:0]    id_src_b,
  input  logic [3:0]         id_alu_op,
  input  logic               id_is_div,
  input  logic               id_div_signed,
  input  logic [4:0]         id_waddr,
  input  logic               id_rwen,
  input  logic [EXC_W-1:0]   id_exc,
  input  logic               mem_allowin,
  output logic               exe_to_mem_valid,
  output logic [XLEN-1:0]    exe_pc,
  output logic [XLEN-1:0]    exe_result,
  output logic [XLEN-1:0]    exe_hi,
  output logic [XLEN-1:0]    exe_lo,
  output logic               exe_hilo_we,
  output logic [4:0]         exe_waddr,
  output logic               exe_rwen,
  output logic [EXC_W:0]     exe_exc
);

  localparam int SHW  = $clog2(XLEN);
  localparam int CNTW = $clog2(XLEN + 1);
  localparam int MSB  = XLEN - 1;
  localparam logic [CNTW-1:0] C_CNT_ONE  = CNTW'(1);
  localparam logic [CNTW-1:0] C_CNT_INIT = CNTW'(XLEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Held instruction
  logic              r_valid;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic [3:0]        r_op;
  logic              r_is_div;
  logic [4:0]        r_waddr;
  logic              r_rwen;
  logic [EXC_W-1:0]  r_exc;

  // Divider state
  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNTW-1:0]   r_cnt;
  logic [XLEN-1:0]   r_quo;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_dvsr;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_dbz;

  logic              w_ready_go;
  logic              w_accept;
  logic              w_div_start;
  logic              w_handoff;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic [XLEN:0]     w_shifted;
  logic [XLEN:0]     w_trial;
  logic [XLEN-1:0]   w_alu;
  logic [XLEN-1:0]   w_sum;
  logic [XLEN-1:0]   w_diff;
  logic              w_ovf;
  logic [SHW-1:0]    w_shamt;

  // ---------------------------------------------------------------- handshake
  // A divide only blocks while it is actually iterating; one with an upstream
  // exception never starts the divider and passes straight through.
  assign w_ready_go       = ~r_is_div | (r_state == S_DONE) | (|r_exc);
  assign exe_allowin      = ~r_valid | (w_ready_go & mem_allowin);
  assign exe_to_mem_valid = r_valid & w_ready_go & ~flush;
  assign w_accept         = id_to_exe_valid & exe_allowin & ~flush;
  assign w_div_start      = w_accept & id_is_div & ~(|id_exc);
  assign w_handoff        = exe_to_mem_valid & mem_allowin;

  // Payload capture; frozen while the stage cannot accept
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_pc     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_is_div <= 1'b0;
      r_waddr  <= '0;
      r_rwen   <= 1'b0;
      r_exc    <= '0;
    end else if (flush) begin
      r_valid  <= 1'b0;
    end else if (w_accept) begin
      r_valid  <= 1'b1;
      r_pc     <= id_pc;
      r_a      <= id_src_a;
      r_b      <= id_src_b;
      r_op     <= id_alu_op;
      r_is_div <= id_is_div;
      r_waddr  <= id_waddr;
      r_rwen   <= id_rwen;
      r_exc    <= id_exc;
    end else if (exe_allowin) begin
      r_valid  <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- divider FSM
  // Divider state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: flush wins, then a fresh divide (possibly in the handoff cycle)
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = S_IDLE;
    end else if (w_div_start) begin
      w_state_nxt = S_BUSY;
    end else begin
      case (r_state)
        S_BUSY:  if (r_cnt == C_CNT_ONE) w_state_nxt = S_DONE;
        S_DONE:  if (w_handoff)          w_state_nxt = S_IDLE;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // Operands are reduced to magnitudes; signs are restored after iterating
  assign w_a_mag   = (id_div_signed & id_src_a[MSB]) ? -id_src_a : id_src_a;
  assign w_b_mag   = (id_div_signed & id_src_b[MSB]) ? -id_src_b : id_src_b;
  assign w_shifted = {r_rem, r_quo[MSB]};
  assign w_trial   = w_shifted - {1'b0, r_dvsr};

  // Restoring shift-subtract: one quotient bit per cycle while busy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_dvsr  <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dbz   <= 1'b0;
    end else if (flush) begin
      r_cnt   <= '0;
    end else if (w_div_start) begin
      r_cnt   <= C_CNT_INIT;
      r_quo   <= w_a_mag;
      r_rem   <= '0;
      r_dvsr  <= w_b_mag;
      r_neg_q <= id_div_signed & (id_src_a[MSB] ^ id_src_b[MSB]);
      r_neg_r <= id_div_signed & id_src_a[MSB];
      r_dbz   <= (id_src_b == '0);
    end else if (r_state == S_BUSY) begin
      r_cnt <= r_cnt - C_CNT_ONE;
      if (!w_trial[XLEN]) begin
        r_rem <= w_trial[XLEN-1:0];
        r_quo <= {r_quo[XLEN-2:0], 1'b1};
      end else begin
        r_rem <= w_shifted[XLEN-1:0];
        r_quo <= {r_quo[XLEN-2:0], 1'b0};
      end
    end
  end

  // Divide by zero bypasses the sign fix-up: all-ones quotient, dividend as rest
  assign exe_lo = r_dbz ? '1  : (r_neg_q ? -r_quo : r_quo);
  assign exe_hi = r_dbz ? r_a : (r_neg_r ? -r_rem : r_rem);

  // ---------------------------------------------------------------- ALU
  assign w_shamt = r_a[SHW-1:0];
  assign w_sum   = r_a + r_b;
  assign w_diff  = r_a - r_b;

  // ALU result select; unused opcodes give zero
  always_comb begin
    w_alu = '0;
    case (r_op)
      4'd0:  w_alu = r_a & r_b;
      4'd1:  w_alu = r_a | r_b;
      4'd2:  w_alu = w_sum;
      4'd3:  w_alu = w_sum;
      4'd4:  w_alu = w_diff;
      4'd5:  w_alu = w_diff;
      4'd6:  w_alu = {{(XLEN-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
      4'd7:  w_alu = {{(XLEN-1){1'b0}}, (r_a < r_b)};
      4'd8:  w_alu = r_a ^ r_b;
      4'd9:  w_alu = ~(r_a | r_b);
      4'd10: w_alu = r_b << w_shamt;
      4'd11: w_alu = r_b >> w_shamt;
      4'd12: w_alu = $signed(r_b) >>> w_shamt;
      4'd13: w_alu = r_b << 16;
      default: w_alu = '0;
    endcase
  end

  // Signed overflow: operands agree in sign (add) or differ (sub) and the
  // result sign departs from operand A
  assign w_ovf = ((r_op == 4'd2) & (r_a[MSB] == r_b[MSB]) & (w_sum[MSB]  != r_a[MSB]))
               | ((r_op == 4'd4) & (r_a[MSB] != r_b[MSB]) & (w_diff[MSB] != r_a[MSB]));

  assign exe_result  = w_alu;
  assign exe_pc      = r_pc;
  assign exe_waddr   = r_waddr;
  assign exe_exc     = {r_exc, w_ovf};
  assign exe_rwen    = r_rwen & ~(|exe_exc);
  assign exe_hilo_we = r_is_div & ~(|exe_exc);

endmodule
`default_nettype wire

// File: tb/tb_exe_stage_hs.sv
`default_nettype none
// ============================================================================
// Module   : tb_exe_stage_hs
// Brief    : Self-checking bench for exe_stage_hs: transaction-level model
//            compared every cycle, plus directed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exe_stage_hs;

  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst, flush, id_to_exe_valid, mem_allowin;
  logic [31:0] id_pc, id_src_a, id_src_b;
  logic [3:0]  id_alu_op, id_exc;
  logic        id_is_div, id_div_signed, id_rwen;
  logic [4:0]  id_waddr;
  logic        exe_allowin, exe_to_mem_valid, exe_hilo_we, exe_rwen;
  logic [31:0] exe_pc, exe_result, exe_hi, exe_lo;
  logic [4:0]  exe_waddr, exe_exc;

  int checks = 0;
  int errors = 0;
  logic en = 1'b0;

  exe_stage_hs #(.XLEN(32), .EXC_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .id_to_exe_valid(id_to_exe_valid),
    .exe_allowin(exe_allowin), .id_pc(id_pc), .id_src_a(id_src_a), .id_src_b(id_src_b),
    .id_alu_op(id_alu_op), .id_is_div(id_is_div), .id_div_signed(id_div_signed),
    .id_waddr(id_waddr), .id_rwen(id_rwen), .id_exc(id_exc), .mem_allowin(mem_allowin),
    .exe_to_mem_valid(exe_to_mem_valid), .exe_pc(exe_pc), .exe_result(exe_result),
    .exe_hi(exe_hi), .exe_lo(exe_lo), .exe_hilo_we(exe_hilo_we), .exe_waddr(exe_waddr),
    .exe_rwen(exe_rwen), .exe_exc(exe_exc)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100000ns, required to finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ------------------------------------------------------------ reference model
  logic        m_valid = 1'b0, m_div = 1'b0, m_sgn = 1'b0, m_rwen = 1'b0, m_clean = 1'b1;
  logic [31:0] m_pc = '0, m_a = '0, m_b = '0;
  logic [3:0]  m_op = '0, m_exc = '0;
  logic [4:0]  m_waddr = '0;
  int          m_age = 0;

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2, 4'd3: return a + b;
      4'd4, 4'd5: return a - b;
      4'd6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd7:  return (a < b) ? 32'd1 : 32'd0;
      4'd8:  return a ^ b;
      4'd9:  return ~(a | b);
      4'd10: return b << a[4:0];
      4'd11: return b >> a[4:0];
      4'd12: return $signed(b) >>> a[4:0];
      4'd13: return {b[15:0], 16'h0000};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ovf_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint s;
    if (op == 4'd2)      s = longint'($signed(a)) + longint'($signed(b));
    else if (op == 4'd4) s = longint'($signed(a)) - longint'($signed(b));
    else return 1'b0;
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  function automatic logic [31:0] lo_ref(input logic sg, input logic [31:0] a, input logic [31:0] b);
    longint q;
    if (b == 32'd0) return 32'hFFFF_FFFF;
    if (!sg) return a / b;
    q = longint'($signed(a)) / longint'($signed(b));
    return q[31:0];
  endfunction

  function automatic logic [31:0] hi_ref(input logic sg, input logic [31:0] a, input logic [31:0] b);
    longint r;
    if (b == 32'd0) return a;
    if (!sg) return a % b;
    r = longint'($signed(a)) % longint'($signed(b));
    return r[31:0];
  endfunction

  function automatic logic m_ready();
    return !m_div || (m_exc != 4'd0) || (m_age >= XLEN);
  endfunction

  function automatic logic m_allowin();
    return !m_valid || (m_ready() && mem_allowin);
  endfunction

  function automatic logic m_clear();
    return ({m_exc, ovf_ref(m_op, m_a, m_b)} == 5'd0);
  endfunction

  // Model advance on each edge from the inputs the bench is driving
  always @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0; m_pc <= '0; m_a <= '0; m_b <= '0; m_op <= '0;
      m_div <= 1'b0; m_sgn <= 1'b0; m_waddr <= '0; m_rwen <= 1'b0; m_exc <= '0;
      m_age <= 0; m_clean <= 1'b1;
    end else if (flush) begin
      m_valid <= 1'b0;
    end else if (id_to_exe_valid && m_allowin()) begin
      m_valid <= 1'b1; m_pc <= id_pc; m_a <= id_src_a; m_b <= id_src_b; m_op <= id_alu_op;
      m_div <= id_is_div; m_sgn <= id_div_signed; m_waddr <= id_waddr; m_rwen <= id_rwen;
      m_exc <= id_exc; m_age <= 0;
      if (id_is_div && id_exc == 4'd0) m_clean <= 1'b0;
    end else begin
      if (m_allowin()) m_valid <= 1'b0;
      m_age <= m_age + 1;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (en) begin
      chk("allowin", exe_allowin, m_allowin());
      chk("to_mem_valid", exe_to_mem_valid, m_valid && m_ready() && !flush);
      chk("pc", exe_pc, m_pc);
      chk("result", exe_result, alu_ref(m_op, m_a, m_b));
      chk("exc", exe_exc, {m_exc, ovf_ref(m_op, m_a, m_b)});
      chk("rwen", exe_rwen, m_rwen && m_clear());
      chk("waddr", exe_waddr, m_waddr);
      chk("hilo_we", exe_hilo_we, m_div && m_clear());
      if (m_clean) begin
        chk("hi_reset", exe_hi, 32'd0);
        chk("lo_reset", exe_lo, 32'd0);
      end else if (m_valid && m_div && m_exc == 4'd0 && m_ready()) begin
        chk("hi", exe_hi, hi_ref(m_sgn, m_a, m_b));
        chk("lo", exe_lo, lo_ref(m_sgn, m_a, m_b));
      end
    end
  end

  // ------------------------------------------------------------ drivers
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic lneg();
    @(negedge clk); #1;
  endtask

  // Present an instruction and hold it until the accepting edge
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic dv, input logic sg, input logic [3:0] ex);
    int n;
    logic acc;
    id_to_exe_valid = 1'b1; id_alu_op = op; id_src_a = a; id_src_b = b;
    id_is_div = dv; id_div_signed = sg; id_exc = ex; id_rwen = 1'b1;
    id_pc = id_pc + 32'd4; id_waddr = id_waddr + 5'd1;
    n = 0; acc = 1'b0;
    while (!acc && n < 200) begin
      #1;
      acc = exe_allowin && !flush;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) chk("send_accept", 64'd0, 64'd1);
    id_to_exe_valid = 1'b0;
  endtask

  // Count edges from the accepting edge until the result is offered
  task automatic wait_valid(output int edges, output logic saw_allow);
    edges = 0; saw_allow = 1'b0;
    while (edges < 100) begin
      @(negedge clk); #1;
      if (exe_to_mem_valid) break;
      saw_allow = saw_allow | exe_allowin;
      @(posedge clk);
      edges++;
    end
  endtask

  int   e;
  logic sa;

  initial begin
    rst = 1'b1; flush = 1'b0; id_to_exe_valid = 1'b0; mem_allowin = 1'b1;
    id_pc = 32'h0000_1000; id_src_a = '0; id_src_b = '0; id_alu_op = '0;
    id_is_div = 1'b0; id_div_signed = 1'b0; id_waddr = '0; id_rwen = 1'b0; id_exc = '0;
    tick();
    en = 1'b1;
    lneg();
    chk("rst_allowin", exe_allowin, 1'b1);
    chk("rst_valid", exe_to_mem_valid, 1'b0);
    chk("rst_result", exe_result, 32'd0);
    chk("rst_lo", exe_lo, 32'd0);
    rst = 1'b0;

    // ADD overflow vs ADDU
    send(4'd2, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 4'd0);
    lneg();
    chk("t1_add_result", exe_result, 32'h8000_0000);
    chk("t1_add_exc", exe_exc, 5'h01);
    chk("t1_add_rwen", exe_rwen, 1'b0);
    send(4'd3, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 4'd0);
    lneg();
    chk("t1_addu_exc", exe_exc, 5'h00);
    chk("t1_addu_rwen", exe_rwen, 1'b1);

    // Opcode sweep, SUB overflow, shifts and LUI are checked by the model
    for (int op = 0; op < 16; op++) send(op[3:0], 32'h0000_0024, 32'hF00F_80F0, 1'b0, 1'b0, 4'd0);
    send(4'd4, 32'h8000_0000, 32'd1, 1'b0, 1'b0, 4'd0);
    lneg();
    chk("sub_ovf_exc", exe_exc, 5'h01);
    send(4'd13, 32'd0, 32'h0000_ABCD, 1'b0, 1'b0, 4'd0);
    lneg();
    chk("lui_result", exe_result, 32'hABCD_0000);

    // DIV -7/2
    send(4'd0, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 4'd0);
    wait_valid(e, sa);
    chk("t2_latency", e, 32);
    chk("t2_allowin_busy", sa, 1'b0);
    chk("t2_lo", exe_lo, 32'hFFFF_FFFD);
    chk("t2_hi", exe_hi, 32'hFFFF_FFFF);
    chk("t2_hilo_we", exe_hilo_we, 1'b1);

    // DIVU by zero
    send(4'd0, 32'h10, 32'd0, 1'b1, 1'b0, 4'd0);
    wait_valid(e, sa);
    chk("t3_latency", e, 32);
    chk("t3_lo", exe_lo, 32'hFFFF_FFFF);
    chk("t3_hi", exe_hi, 32'h0000_0010);

    // Divide carrying an upstream exception passes straight through
    send(4'd0, 32'd5, 32'd1, 1'b1, 1'b1, 4'h2);
    lneg();
    chk("exc_div_valid", exe_to_mem_valid, 1'b1);
    chk("exc_div_hilo_we", exe_hilo_we, 1'b0);
    tick();

    // Back-pressure from MEM
    mem_allowin = 1'b0;
    send(4'd3, 32'd5, 32'd6, 1'b0, 1'b0, 4'd0);
    id_to_exe_valid = 1'b1; id_alu_op = 4'd3; id_src_a = 32'd1; id_src_b = 32'd2;
    id_is_div = 1'b0; id_exc = 4'd0; id_pc = id_pc + 32'd4;
    for (int i = 0; i < 3; i++) begin
      lneg();
      chk("t4_hold_result", exe_result, 32'd11);
      chk("t4_hold_allowin", exe_allowin, 1'b0);
      chk("t4_hold_valid", exe_to_mem_valid, 1'b1);
    end
    mem_allowin = 1'b1;
    #1;
    chk("t4_release_allowin", exe_allowin, 1'b1);
    tick();
    id_to_exe_valid = 1'b0;
    lneg();
    chk("t4_next_result", exe_result, 32'd3);

    // Flush in the tenth cycle of a divide
    send(4'd0, 32'd100, 32'd7, 1'b1, 1'b1, 4'd0);
    repeat (9) tick();
    flush = 1'b1;
    #1;
    chk("t5_flush_valid", exe_to_mem_valid, 1'b0);
    tick();
    flush = 1'b0;
    #1;
    chk("t5_after_allowin", exe_allowin, 1'b1);
    chk("t5_after_valid", exe_to_mem_valid, 1'b0);
    send(4'd0, 32'd9, 32'd3, 1'b1, 1'b0, 4'd0);
    wait_valid(e, sa);
    chk("t5_latency", e, 32);
    chk("t5_lo", exe_lo, 32'd3);
    chk("t5_hi", exe_hi, 32'd0);

    // Reset pulse in the middle of a divide
    send(4'd0, 32'd1000, 32'd3, 1'b1, 1'b1, 4'd0);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("t6_allowin", exe_allowin, 1'b1);
    chk("t6_valid", exe_to_mem_valid, 1'b0);
    chk("t6_pc", exe_pc, 32'd0);
    chk("t6_hi", exe_hi, 32'd0);
    chk("t6_lo", exe_lo, 32'd0);
    chk("t6_exc", exe_exc, 5'd0);
    chk("t6_hilo_we", exe_hilo_we, 1'b0);
    send(4'd6, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 4'd0);
    lneg();
    chk("t6_slt", exe_result, 32'd1);
    send(4'd7, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 4'd0);
    lneg();
    chk("t6_sltu", exe_result, 32'd0);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
